alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_mul.sv | 50 +++++
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and flag bit positions.
// Build option: ALU_SEQ_MUL_EN adds the multi-cycle shift-add multiplier.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_THR = 4'd0,
    OP_ADD = 4'd1,
    OP_ADC = 4'd2,
    OP_SUB = 4'd3,
    OP_SBC = 4'd4,
    OP_SHL = 4'd5,
    OP_ROL = 4'd6,
    OP_SHR = 4'd7,
    OP_ROR = 4'd8,
    OP_AND = 4'd9,
    OP_OR  = 4'd10,
    OP_XOR = 4'd11,
    OP_NOT = 4'd12,
    OP_MUL = 4'd13
  } alu_op_e;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} alu_state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} alu_state_e;
`endif

  // Bit positions inside flags = {negative, overflow, carry, zero}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_NEG   = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier, one partial product per clock.
// Only instantiated when ALU_SEQ_MUL_EN is defined.
module alu_mul_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   mcand_in,
  input  logic [DATA_WIDTH-1:0]   mplier_in,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    last
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] mcand_q;
  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0]   mplier_q;
  logic [CW-1:0]           count_q;
  logic                    busy_q;

  // The product leaving on the final step is the accumulator plus that step's partial
  // product, so the result is ready on the same edge the last step would be taken.
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last    = busy_q && (count_q == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{DATA_WIDTH{1'b0}}, mcand_in};
      acc_q    <= '0;
      mplier_q <= mplier_in;
      count_q  <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
      busy_q   <= !last;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; single-cycle ops finish one edge after accept.
// Build option: ALU_SEQ_MUL_EN enables the DATA_WIDTH-cycle unsigned multiply.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] register1,
  input  logic [DATA_WIDTH-1:0] register2,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            flags
);

  localparam int W = DATA_WIDTH;

  alu_state_e state_q, state_d, start_state;
  logic       accept;
  logic       load_alu;
  logic [W:0] ext;
  logic       alu_carry, alu_ovf;
  logic [3:0] alu_flags;

  assign accept   = in_valid && in_ready;
  assign load_alu = accept && (start_state == S_DONE);

`ifdef ALU_SEQ_MUL_EN
  logic [2*W-1:0] mul_product;
  logic           mul_last;
  logic           load_mul;
  logic [3:0]     mul_flags;

  assign start_state = (op == OP_MUL) ? S_MUL : S_DONE;
  assign load_mul    = (state_q == S_MUL) && mul_last;

  alu_mul_seq #(.DATA_WIDTH(W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && (op == OP_MUL)),
    .mcand_in  (register1),
    .mplier_in (register2),
    .product   (mul_product),
    .last      (mul_last)
  );

  always_comb begin
    mul_flags             = '0;
    mul_flags[FLAG_NEG]   = mul_product[2*W-1];
    mul_flags[FLAG_CARRY] = (mul_product[2*W-1:W] != '0);
    mul_flags[FLAG_ZERO]  = (mul_product == '0);
  end
`else
  assign start_state = S_DONE;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = start_state;
`ifdef ALU_SEQ_MUL_EN
      S_MUL:  if (mul_last) state_d = S_DONE;
`endif
      S_DONE: if (out_ready) state_d = accept ? start_state : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
  end

  // Everything is evaluated one bit wider so bit W carries the carry/borrow out.
  always_comb begin
    ext       = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_THR: ext = {1'b0, register1};
      OP_ADD, OP_ADC: begin
        ext = {1'b0, register1} + {1'b0, register2}
              + {{W{1'b0}}, (op == OP_ADC) && flags[FLAG_CARRY]};
        alu_carry = ext[W];
        alu_ovf   = (register1[W-1] == register2[W-1]) && (ext[W-1] != register1[W-1]);
      end
      OP_SUB, OP_SBC: begin
        ext = {1'b0, register1} - {1'b0, register2}
              - {{W{1'b0}}, (op == OP_SBC) && flags[FLAG_CARRY]};
        alu_carry = ext[W];
        alu_ovf   = (register1[W-1] != register2[W-1]) && (ext[W-1] != register1[W-1]);
      end
      OP_SHL: begin
        ext       = {register1, 1'b0};
        alu_carry = ext[W];
      end
      OP_ROL: ext = {1'b0, register1[W-2:0], register1[W-1]};
      OP_SHR: begin
        ext       = {2'b00, register1[W-1:1]};
        alu_carry = register1[0];
      end
      OP_ROR: ext = {1'b0, register1[0], register1[W-1:1]};
      OP_AND: ext = {1'b0, register1 & register2};
      OP_OR:  ext = {1'b0, register1 | register2};
      OP_XOR: ext = {1'b0, register1 ^ register2};
      OP_NOT: ext = {1'b0, ~register1};
      default: ext = '0;
    endcase
    alu_flags             = '0;
    alu_flags[FLAG_NEG]   = ext[W-1];
    alu_flags[FLAG_OVF]   = alu_ovf;
    alu_flags[FLAG_CARRY] = alu_carry;
    alu_flags[FLAG_ZERO]  = (ext[W-1:0] == '0);
  end

  // Results and flags only change when entering DONE, so they persist through IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else if (load_alu) begin
      result    <= ext[W-1:0];
      result_hi <= '0;
      flags     <= alu_flags;
`ifdef ALU_SEQ_MUL_EN
    end else if (load_mul) begin
      result    <= mul_product[W-1:0];
      result_hi <= mul_product[2*W-1:W];
      flags     <= mul_flags;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at DATA_WIDTH = 8.
// Covers both builds; multiply expectations depend on ALU_SEQ_MUL_EN.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  alu_op_e    op;
  logic [7:0] register1, register2;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] result, result_hi;
  logic [3:0] flags;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .register1 (register1),
    .register2 (register2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .result_hi (result_hi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Presents one request for a single edge, then drops in_valid.
  task automatic applyStimulus(input alu_op_e o, input logic [7:0] a, input logic [7:0] b);
    op        = o;
    register1 = a;
    register2 = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    alu_op_e    o;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
    string      tag;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int  cycles;
    bit  ready_seen;
    bit  valid_seen;

    vecs[0] = '{OP_SHL, 8'h81, 8'h00, 8'h02, 4'b0010, "shl"};
    vecs[1] = '{OP_ROL, 8'h81, 8'h00, 8'h03, 4'b0000, "rol"};
    vecs[2] = '{OP_SHR, 8'h81, 8'h00, 8'h40, 4'b0010, "shr"};
    vecs[3] = '{OP_ROR, 8'h81, 8'h00, 8'hC0, 4'b1000, "ror"};
    vecs[4] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, "and"};
    vecs[5] = '{OP_OR,  8'hF0, 8'h3C, 8'hFC, 4'b1000, "or"};
    vecs[6] = '{OP_XOR, 8'hF0, 8'h3C, 8'hCC, 4'b1000, "xor"};
    vecs[7] = '{OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'b1000, "not"};
    vecs[8] = '{OP_THR, 8'h00, 8'h77, 8'h00, 4'b0001, "thr_zero"};
    vecs[9] = '{alu_op_e'(4'hF), 8'h55, 8'hAA, 8'h00, 4'b0001, "undef_op"};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_THR; register1 = '0; register2 = '0;
    tick(); tick();
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_result_hi", result_hi, 0);
    checkOutput("reset_flags", flags, 0);
    rst_n = 1'b1;
    tick();

    applyStimulus(OP_ADD, 8'hFF, 8'h01);
    checkOutput("add_ff_valid", out_valid, 1);
    checkOutput("add_ff_result", result, 8'h00);
    checkOutput("add_ff_flags", flags, 4'b0011);
    tick();
    checkOutput("idle_after_done", out_valid, 0);
    checkOutput("flags_persist_idle", flags, 4'b0011);

    applyStimulus(OP_ADD, 8'h7F, 8'h01);
    checkOutput("add_7f_result", result, 8'h80);
    checkOutput("add_7f_flags", flags, 4'b1100);
    tick();
    applyStimulus(OP_SUB, 8'h00, 8'h01);
    checkOutput("sub_result", result, 8'hFF);
    checkOutput("sub_flags", flags, 4'b1010);
    tick();
    applyStimulus(OP_ADC, 8'h10, 8'h20);
    checkOutput("adc_result", result, 8'h31);
    checkOutput("adc_flags", flags, 4'b0000);
    tick();
    applyStimulus(OP_SUB, 8'h00, 8'h01);
    tick();
    applyStimulus(OP_SBC, 8'h10, 8'h05);
    checkOutput("sbc_result", result, 8'h0A);
    checkOutput("sbc_flags", flags, 4'b0000);
    tick();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].o, vecs[i].a, vecs[i].b);
      checkOutput({vecs[i].tag, "_valid"}, out_valid, 1);
      checkOutput({vecs[i].tag, "_result"}, result, vecs[i].res);
      checkOutput({vecs[i].tag, "_hi"}, result_hi, 0);
      checkOutput({vecs[i].tag, "_flags"}, flags, vecs[i].flg);
      tick();
    end

    // Back-pressure: DONE holds while a competing request is ignored.
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 8'h05, 8'h03);
    op = OP_SUB; register1 = 8'h01; register2 = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_result", result, 8'h08);
      checkOutput("hold_flags", flags, 4'b0000);
    end
    out_ready = 1'b1; #1;
    checkOutput("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("chained_valid", out_valid, 1);
    checkOutput("chained_result", result, 8'h00);
    checkOutput("chained_flags", flags, 4'b0001);
    tick();

`ifdef ALU_SEQ_MUL_EN
    applyStimulus(OP_MUL, 8'hFF, 8'hFF);
    cycles = 1; ready_seen = 1'b0;
    while (!out_valid && cycles < 20) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      cycles++;
    end
    checkOutput("mul_latency", cycles, 9);
    checkOutput("mul_in_ready_low", ready_seen, 0);
    checkOutput("mul_result", result, 8'h01);
    checkOutput("mul_result_hi", result_hi, 8'hFE);
    checkOutput("mul_flags", flags, 4'b1010);
    tick();

    applyStimulus(OP_MUL, 8'h03, 8'h05);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    checkOutput("mulrst_out_valid", out_valid, 0);
    checkOutput("mulrst_in_ready", in_ready, 1);
    checkOutput("mulrst_result", result, 0);
    checkOutput("mulrst_result_hi", result_hi, 0);
    checkOutput("mulrst_flags", flags, 0);
    rst_n = 1'b1;
    valid_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) valid_seen = 1'b1;
    end
    checkOutput("mulrst_no_valid", valid_seen, 0);
`else
    applyStimulus(OP_NOT, 8'h0F, 8'h00);
    tick();
    applyStimulus(OP_MUL, 8'h03, 8'h05);
    checkOutput("mul_off_valid", out_valid, 1);
    checkOutput("mul_off_result", result, 8'h00);
    checkOutput("mul_off_hi", result_hi, 8'h00);
    checkOutput("mul_off_flags", flags, 4'b0001);
    tick();
`endif

    // Reset while a result is waiting in DONE.
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 8'h7F, 8'h01);
    checkOutput("donerst_pre_result", result, 8'h80);
    rst_n = 1'b0;
    tick();
    checkOutput("donerst_out_valid", out_valid, 0);
    checkOutput("donerst_in_ready", in_ready, 1);
    checkOutput("donerst_result", result, 0);
    checkOutput("donerst_flags", flags, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
